// File: rtl/payload_writer.sv
// rtl/payload_writer.sv - packet-to-block writer for the payload buffer, emits packet descriptors
// Optional PAYLOAD_WRITER_DROP_EN: drop packets that do not fit instead of stalling.
module payload_writer #(
    parameter int DATA_BYTES = 16,
    parameter int ADDR_W     = 10,
    parameter int CAP_W      = 11,
    parameter int TTL_W      = 8,
    parameter int LEN_W      = 14,
    parameter int BCNT_W     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [BCNT_W-1:0]       in_bytes,
    input  logic [LEN_W-1:0]        in_len,
    input  logic [TTL_W-1:0]        in_ttl,
    output logic                    wr_isLast,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic [TTL_W-1:0]        wr_ttl,
    output logic [BCNT_W-1:0]       wr_byteCount,
    input  logic [ADDR_W-1:0]       wr_address,
    input  logic [CAP_W-1:0]        wr_capacity,
    output logic                    desc_valid,
    input  logic                    desc_ready,
    output logic [ADDR_W-1:0]       desc_addr,
    output logic [LEN_W-1:0]        desc_len,
    output logic [TTL_W-1:0]        desc_ttl,
`ifdef PAYLOAD_WRITER_DROP_EN
    output logic [15:0]             drop_count,
`endif
    output logic                    err_len
);

    localparam int NW = LEN_W + 1;
    localparam int CW = (CAP_W > NW) ? CAP_W : NW;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_STREAM, S_FINAL, S_DESC, S_DROP
    } state_t;

    state_t           state;
    logic [NW-1:0]    need_calc;
    logic [NW-1:0]    need_q;
    logic [NW-1:0]    beat_cnt;
    logic [LEN_W-1:0] byte_acc;
    logic [TTL_W-1:0] ttl_q;
    logic             accept;
    logic             cap_ok;

    // Zero-length packets still occupy one block.
    always_comb begin
        need_calc = ({1'b0, in_len} + NW'(DATA_BYTES - 1)) / NW'(DATA_BYTES);
        if (in_len == '0) begin
            need_calc = NW'(1);
        end
    end

    assign accept = in_valid && in_ready && (state == S_STREAM);
    assign cap_ok = CW'(wr_capacity) >= CW'(need_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            in_ready     <= 1'b0;
            wr_isLast    <= 1'b0;
            wr_data      <= '0;
            wr_ttl       <= '0;
            wr_byteCount <= '0;
            desc_valid   <= 1'b0;
            desc_addr    <= '0;
            desc_len     <= '0;
            desc_ttl     <= '0;
            err_len      <= 1'b0;
            need_q       <= '0;
            beat_cnt     <= '0;
            byte_acc     <= '0;
            ttl_q        <= '0;
`ifdef PAYLOAD_WRITER_DROP_EN
            drop_count   <= '0;
`endif
        end else begin
            wr_byteCount <= '0;
            wr_isLast    <= 1'b0;
            err_len      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_sop) begin
                        need_q   <= need_calc;
                        ttl_q    <= in_ttl;
                        beat_cnt <= '0;
                        byte_acc <= '0;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cap_ok) begin
                        in_ready <= 1'b1;
                        state    <= S_STREAM;
                    end
`ifdef PAYLOAD_WRITER_DROP_EN
                    else begin
                        in_ready <= 1'b1;
                        state    <= S_DROP;
                    end
`endif
                end
                S_STREAM: begin
                    if (accept) begin
                        wr_byteCount <= in_bytes;
                        wr_data      <= in_data;
                        wr_ttl       <= ttl_q;
                        wr_isLast    <= (beat_cnt == '0);
                        beat_cnt     <= beat_cnt + NW'(1);
                        byte_acc     <= byte_acc + LEN_W'(in_bytes);
                        if (in_eop) begin
                            in_ready <= 1'b0;
                            state    <= S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    // Last block is on the bus now, so wr_address is the list head.
                    desc_addr  <= wr_address;
                    desc_len   <= byte_acc;
                    desc_ttl   <= ttl_q;
                    desc_valid <= 1'b1;
                    err_len    <= (beat_cnt != need_q);
                    state      <= S_DESC;
                end
                S_DESC: begin
                    if (desc_ready) begin
                        desc_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
`ifdef PAYLOAD_WRITER_DROP_EN
                S_DROP: begin
                    if (in_valid && in_ready && in_eop) begin
                        in_ready <= 1'b0;
                        if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                        state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    in_ready <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payload_writer.sv
// tb/tb_payload_writer.sv - directed self-checking bench for payload_writer
// Exercises the PAYLOAD_WRITER_DROP_EN path when that macro is defined.
module tb_payload_writer;

    localparam int DATA_BYTES = 16;
    localparam int ADDR_W     = 10;
    localparam int CAP_W      = 11;
    localparam int TTL_W      = 8;
    localparam int LEN_W      = 14;
    localparam int BCNT_W     = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sop;
    logic                    in_eop;
    logic [8*DATA_BYTES-1:0] in_data;
    logic [BCNT_W-1:0]       in_bytes;
    logic [LEN_W-1:0]        in_len;
    logic [TTL_W-1:0]        in_ttl;
    logic                    wr_isLast;
    logic [8*DATA_BYTES-1:0] wr_data;
    logic [TTL_W-1:0]        wr_ttl;
    logic [BCNT_W-1:0]       wr_byteCount;
    logic [ADDR_W-1:0]       wr_address;
    logic [CAP_W-1:0]        wr_capacity;
    logic                    desc_valid;
    logic                    desc_ready;
    logic [ADDR_W-1:0]       desc_addr;
    logic [LEN_W-1:0]        desc_len;
    logic [TTL_W-1:0]        desc_ttl;
    logic                    err_len;
`ifdef PAYLOAD_WRITER_DROP_EN
    logic [15:0]             drop_count;
`endif

    payload_writer #(
        .DATA_BYTES(DATA_BYTES), .ADDR_W(ADDR_W), .CAP_W(CAP_W),
        .TTL_W(TTL_W), .LEN_W(LEN_W), .BCNT_W(BCNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .in_data(in_data), .in_bytes(in_bytes), .in_len(in_len), .in_ttl(in_ttl),
        .wr_isLast(wr_isLast), .wr_data(wr_data), .wr_ttl(wr_ttl),
        .wr_byteCount(wr_byteCount), .wr_address(wr_address), .wr_capacity(wr_capacity),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
        .desc_len(desc_len), .desc_ttl(desc_ttl),
`ifdef PAYLOAD_WRITER_DROP_EN
        .drop_count(drop_count),
`endif
        .err_len(err_len)
    );

    always #5 clk = ~clk;

    // Buffer address moves every cycle so the captured pointer is cycle-specific.
    always @(posedge clk) wr_address <= wr_address + 10'd7;

    int chk_n  = 0;
    int pass_n = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Write-bus and descriptor monitor
    logic                    w_last [0:63];
    logic [TTL_W-1:0]        w_ttl  [0:63];
    logic [BCNT_W-1:0]       w_bc   [0:63];
    logic [ADDR_W-1:0]       w_addr [0:63];
    logic [8*DATA_BYTES-1:0] w_data [0:63];
    logic [ADDR_W-1:0]       d_addr [0:15];
    logic [LEN_W-1:0]        d_len  [0:15];
    logic [TTL_W-1:0]        d_ttl  [0:15];
    int wr_n = 0, desc_n = 0, err_n = 0;

    always @(negedge clk) begin
        if (wr_byteCount != '0 && wr_n < 64) begin
            w_last[wr_n] = wr_isLast;
            w_ttl[wr_n]  = wr_ttl;
            w_bc[wr_n]   = wr_byteCount;
            w_addr[wr_n] = wr_address;
            w_data[wr_n] = wr_data;
            wr_n++;
        end
        if (desc_valid && desc_ready && desc_n < 16) begin
            d_addr[desc_n] = desc_addr;
            d_len[desc_n]  = desc_len;
            d_ttl[desc_n]  = desc_ttl;
            desc_n++;
        end
        if (err_len) err_n++;
    end

    function automatic logic [8*DATA_BYTES-1:0] pat(input int k);
        logic [7:0] b;
        b = 8'(k) + 8'hA0;
        return {DATA_BYTES{b}};
    endfunction

    task automatic send_pkt(input int len, input int ttl, input int nb, input int lastb);
        for (int k = 0; k < nb; k++) begin
            int t;
            in_valid = 1'b1;
            in_sop   = (k == 0);
            in_eop   = (k == nb - 1);
            in_bytes = (k == nb - 1) ? BCNT_W'(lastb) : BCNT_W'(DATA_BYTES);
            in_data  = pat(k);
            in_len   = LEN_W'(len);
            in_ttl   = TTL_W'(ttl);
            t = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                t++;
                if (t > 300) break;
            end
            if (t > 300) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic wait_desc(input int n);
        int t = 0;
        while (desc_n < n && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("desc_wait", desc_n >= n, 1);
    endtask

    initial begin
        int wb, db, eb, bad;
        logic [ADDR_W-1:0] a0;
        logic [LEN_W-1:0]  l0;
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data = '0; in_bytes = '0; in_len = '0; in_ttl = '0;
        wr_address = '0; wr_capacity = 11'd100; desc_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_bc", wr_byteCount, 0);
        check("rst_desc_valid", desc_valid, 0);
        check("rst_err_len", err_len, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef PAYLOAD_WRITER_DROP_EN
        wb = wr_n; db = desc_n;
        wr_capacity = 11'd0;
        send_pkt(20, 3, 2, 4);
        send_pkt(40, 3, 3, 8);
        repeat (5) @(posedge clk); #1;
        check("drop_writes", wr_n, wb);
        check("drop_descs", desc_n, db);
        check("drop_count", drop_count, 2);
        wr_capacity = 11'd100;
`endif

        // 40-byte packet, three blocks
        wb = wr_n; db = desc_n; eb = err_n;
        send_pkt(40, 5, 3, 8);
        wait_desc(db + 1);
        check("p40_writes", wr_n - wb, 3);
        check("p40_last0", w_last[wb], 1);
        check("p40_last1", w_last[wb+1], 0);
        check("p40_last2", w_last[wb+2], 0);
        check("p40_ttl0", w_ttl[wb], 5);
        check("p40_ttl2", w_ttl[wb+2], 5);
        check("p40_bc0", w_bc[wb], 16);
        check("p40_bc1", w_bc[wb+1], 16);
        check("p40_bc2", w_bc[wb+2], 8);
        check("p40_data1", w_data[wb+1], pat(1));
        check("p40_addr", d_addr[db], w_addr[wb+2]);
        check("p40_len", d_len[db], 40);
        check("p40_ttl", d_ttl[db], 5);
        check("p40_err", err_n - eb, 0);

        // Single-block packet
        wb = wr_n; db = desc_n;
        send_pkt(16, 200, 1, 16);
        wait_desc(db + 1);
        check("p16_writes", wr_n - wb, 1);
        check("p16_last", w_last[wb], 1);
        check("p16_bc", w_bc[wb], 16);
        check("p16_addr", d_addr[db], w_addr[wb]);
        check("p16_ttl", d_ttl[db], 200);

        // Capacity one short of need stalls, exact need admits
        wb = wr_n; db = desc_n;
        wr_capacity = 11'd2;
        bad = 0;
        fork
            send_pkt(48, 7, 3, 16);
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (in_ready) bad++;
                end
                check("cap_stall_ready", bad, 0);
                check("cap_stall_writes", wr_n - wb, 0);
                wr_capacity = 11'd3;
            end
        join
        wait_desc(db + 1);
        check("cap_writes", wr_n - wb, 3);
        check("cap_len", d_len[db], 48);
        wr_capacity = 11'd100;

        // Descriptor backpressure holds outputs and blocks the next packet
        wb = wr_n; db = desc_n;
        desc_ready = 1'b0;
        send_pkt(16, 9, 1, 16);
        fork
            send_pkt(32, 11, 2, 16);
            begin
                int t = 0;
                while (!desc_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                a0 = desc_addr;
                l0 = desc_len;
                bad = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (!desc_valid || desc_addr != a0 || desc_len != l0 || in_ready) bad++;
                end
                check("bp_stable", bad, 0);
                check("bp_writes", wr_n - wb, 1);
                @(posedge clk); #1;
                desc_ready = 1'b1;
            end
        join
        wait_desc(db + 2);
        check("bp_d0_addr", d_addr[db], w_addr[wb]);
        check("bp_d0_len", d_len[db], 16);
        check("bp_d1_len", d_len[db+1], 32);
        check("bp_d1_ttl", d_ttl[db+1], 11);
        check("bp_writes_total", wr_n - wb, 3);

        // Short packet: declared 48, delivered 26
        wb = wr_n; db = desc_n; eb = err_n;
        send_pkt(48, 4, 2, 10);
        wait_desc(db + 1);
        repeat (2) @(posedge clk); #1;
        check("short_writes", wr_n - wb, 2);
        check("short_bc1", w_bc[wb+1], 10);
        check("short_len", d_len[db], 26);
        check("short_err", err_n - eb, 1);

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
